// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of independent 50%-duty clock dividers; define CLK_DIV_BANK_SYNC_EN to add the sync phase-restart port.
module clk_div_bank #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef CLK_DIV_BANK_SYNC_EN
  input  logic                    sync,
`endif
  input  logic [N_CH-1:0]         en,
  input  logic [N_CH*WIDTH-1:0]   value,
  output logic [N_CH-1:0]         sig,
  output logic [N_CH-1:0]         wrap
);
  logic restart;
`ifdef CLK_DIV_BANK_SYNC_EN
  assign restart = sync;
`else
  assign restart = 1'b0;
`endif
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [WIDTH-1:0] cnt, shd, v;
    logic             s, w, hit;
    assign v   = value[g*WIDTH +: WIDTH];
    assign hit = cnt == shd;
    // shd is reloaded only while idle/restarted or at a wrap, so mid-period value changes wait
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
        shd <= '0;
        s   <= 1'b0;
        w   <= 1'b0;
      end else if (!en[g] || restart) begin
        cnt <= '0;
        shd <= v;
        s   <= 1'b0;
        w   <= 1'b0;
      end else begin
        cnt <= hit ? '0 : cnt + WIDTH'(1);
        shd <= hit ? v : shd;
        s   <= s ^ hit;
        w   <= hit;
      end
    end
    assign sig[g]  = s;
    assign wrap[g] = w;
  end
endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 Parameter N_CH, default 4: number of independent divider channels, legal range 1..16.
REQ-002 Parameter WIDTH, default 24: width of each channel's half-period value, legal range 2..32.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; every register is clocked on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port en, input, N_CH bits: per-channel run enable; bit i controls channel i.
REQ-006 The block SHALL have port value, input, N_CH*WIDTH bits: per-channel half-period count; channel i uses bits [i*WIDTH +: WIDTH].
REQ-007 The block SHALL have port sig, output, N_CH bits: per-channel registered square-wave output.
REQ-008 The block SHALL have port wrap, output, N_CH bits: per-channel one-cycle pulse, asserted in the cycle in which sig[i] takes its new level.
REQ-009 The block SHALL have port sync, input, 1 bit, present only when CLK_DIV_BANK_SYNC_EN is defined: phase-restart strobe.

Function
REQ-010 Each channel SHALL hold a WIDTH-bit counter cnt, a WIDTH-bit shadow register shd, a sig register and a wrap register.
REQ-011 While en[i]=0, channel i SHALL hold cnt=0, sig=0 and wrap=0, and SHALL load shd from value every cycle.
REQ-012 While en[i]=1 and cnt!=shd, channel i SHALL increment cnt by 1, with wrap=0.
REQ-013 While en[i]=1 and cnt==shd, channel i SHALL apply all of the following next cycle:
- cnt=0
- sig inverted
- wrap=1 for exactly one cycle
- shd loaded from the current value
REQ-014 Output period SHALL be 2*(shd+1) clk cycles at 50% duty; value=0 SHALL give a clk/2 output.
REQ-015 A value change while enabled SHALL take effect only at the next wrap; the half-period in progress completes with the old shd.
REQ-016 After en[i] rises, the first sig[i] rising edge SHALL occur shd+1 cycles after the first cycle in which en[i] is sampled high.
REQ-017 When en[i] falls in the same cycle as a wrap condition, disable SHALL win: cnt=0, sig=0, wrap=0.
REQ-018 Channels SHALL be fully independent; no channel's en or value affects another channel's outputs.
REQ-019 The counter SHALL never exceed shd and never wrap past 2^WIDTH-1; value all-ones SHALL give period 2^(WIDTH+1).

Reset
REQ-020 While rst=1, every channel SHALL have cnt=0, shd=0, sig=0 and wrap=0, regardless of en, value and sync.
REQ-021 Reset asserted mid-period SHALL abort the half-period in progress without a wrap pulse.
REQ-022 On the first cycle after rst falls, channels with en=1 SHALL behave per REQ-016, using shd=0 (so the first half-period is 1 cycle) and loading value at that first wrap.

Configuration
REQ-023 Macro CLK_DIV_BANK_SYNC_EN defined: the sync port exists, and sync=1 SHALL force every enabled channel to the following next cycle, with no wrap pulse:
- cnt=0
- sig=0
- shd=value
REQ-024 With CLK_DIV_BANK_SYNC_EN defined, when sync=1 coincides with a wrap condition, sync SHALL win.
REQ-025 With CLK_DIV_BANK_SYNC_EN defined, rst SHALL have priority over sync.
REQ-026 Macro CLK_DIV_BANK_SYNC_EN undefined: the sync port is absent, and behaviour SHALL be exactly REQ-010..REQ-022.

Verification
REQ-027 Defaults; rst 1->0 with en=4'b0001, value ch0=3: after the initial 1-cycle half-period, sig[0] toggles every 4 cycles (period 8); wrap[0] is pulsed on each toggle; sig[3:1] stay 0.
REQ-028 ch1 value=0, en[1]=1: sig[1] toggles every cycle; wrap[1] stays continuously high.
REQ-029 ch2 running at value=9; change value to 2 at cnt=5: the current half-period still lasts 10 cycles, after which half-periods last 3 cycles.
REQ-030 Drop en[0] in the exact wrap cycle: next cycle sig[0]=0, wrap[0]=0, cnt=0; re-raise en[0] with value=3 and the first rising edge comes 4 cycles later.
REQ-031 With SYNC_EN, channels 0..3 at values 1,2,3,4 running: pulse sync; all sig=0 next cycle; first rising edges come 2, 3, 4 and 5 cycles after that.
REQ-032 Assert rst mid-period on all channels for 1 cycle: all outputs are 0 the next cycle and no wrap pulse is seen.
